// File: rtl/binary_mac_sequencer.sv
// ---------------------------------------------------------------------------
// binary_mac_sequencer
//
// Purpose:
//   Computes one neuron's dot product over a binary image. The pixel and
//   weight RAMs are walked in lockstep through a shared address. Each
//   pixel/weight pair is handed to the external single_bit_multiply gating
//   block, and the gated products are accumulated. The final sum is reported
//   with a start/done handshake.
//
// Ports:
//   clk              in   rising-edge clock
//   rst_n            in   synchronous active-low reset
//   start            in   run request, sampled only in IDLE or DONE
//   addr             out  [ADDR_W-1:0] shared pixel/weight read address
//   pixel_in         in   pixel RAM data, valid the cycle after its address
//   weight_in        in   [SIZE-1:0] weight RAM data, valid the cycle after
//   mul_multiplier   out  [SIZE-1:0] combinational copy of weight_in
//   mul_multiplicand out  combinational copy of pixel_in
//   mul_product      in   [SIZE-1:0] multiplier result (combinational)
//   acc_out          out  [ACC_W-1:0] result of the last completed run
//   busy             out  high while in RUN or DRAIN
//   done             out  one-cycle pulse; acc_out valid from this cycle on
//
// Configuration macro:
//   SATURATE_EN  defined   -> the accumulator clamps at 2^ACC_W-1
//                undefined -> the accumulator wraps modulo 2^ACC_W
//
// Timing (cycle 0 = start sampled):
//   cycles 1..N_INPUTS  RUN, addr = cycle-1
//   cycle  N_INPUTS+1   DRAIN (adds the last product)
//   cycle  N_INPUTS+2   DONE  (done=1, acc_out final)
// ---------------------------------------------------------------------------
module binary_mac_sequencer #(
    parameter int unsigned SIZE     = 5,
    parameter int unsigned N_INPUTS = 256,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned ACC_W    = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] addr,
    input  logic              pixel_in,
    input  logic [SIZE-1:0]   weight_in,
    output logic [SIZE-1:0]   mul_multiplier,
    output logic              mul_multiplicand,
    input  logic [SIZE-1:0]   mul_product,
    output logic [ACC_W-1:0]  acc_out,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q,   state_d;
    logic [ADDR_W-1:0]  addr_q,    addr_d;
    logic [ACC_W-1:0]   acc_q,     acc_d;
    logic [ACC_W-1:0]   acc_out_q, acc_out_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               valid_q,   valid_d;

    logic [ACC_W-1:0]   acc_sum;

    // The multiplier sits outside this block; RAM data is forwarded unchanged.
    assign mul_multiplier   = weight_in;
    assign mul_multiplicand = pixel_in;

    assign addr    = addr_q;
    assign acc_out = acc_out_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef SATURATE_EN
    // One extra carry bit detects overflow; once clamped, further non-zero
    // products overflow again so the value stays pinned at the maximum.
    logic [ACC_W:0] sum_ext;

    always_comb begin
        sum_ext = (ACC_W+1)'(acc_q) + (ACC_W+1)'(mul_product);
        acc_sum = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
    end
`else
    // Modulo 2^ACC_W accumulate.
    always_comb begin
        acc_sum = acc_q + ACC_W'(mul_product);
    end
`endif

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        acc_d     = acc_q;
        acc_out_d = acc_out_q;
        done_d    = 1'b0;
        // Data arriving next cycle belongs to an address issued in RUN.
        valid_d   = (state_q == S_RUN);

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    addr_d  = '0;
                    acc_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                // First RUN cycle has no read data yet; valid_q masks it.
                if (valid_q) begin
                    acc_d = acc_sum;
                end
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end

            S_DRAIN: begin
                // Product of the last address arrives here.
                if (valid_q) begin
                    acc_d = acc_sum;
                end
                acc_out_d = acc_d;
                done_d    = 1'b1;
                state_d   = S_DONE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            acc_q     <= '0;
            acc_out_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            acc_q     <= acc_d;
            acc_out_q <= acc_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
        end
    end

endmodule

// File: doc/binary_mac_sequencer.md
# binary_mac_sequencer

Sequences one neuron's dot product over a binary image using the team's `single_bit_multiply` gating block (SIZE-bit weight ANDed with a 1-bit pixel). The block walks the pixel and weight memories in lockstep and feeds each pixel/weight pair to the multiplier. It accumulates the gated products and reports the sum with a start/done handshake. It sits between the image/weight RAMs and the activation stage of the semeion classifier datapath.

## Interface
- SIZE, 5: weight width; matches the multiplier's SIZE.
- N_INPUTS, 256: pixels per image (16x16).
- ADDR_W, 8: address width; must satisfy 2^ADDR_W >= N_INPUTS.
- ACC_W, 13: accumulator width; the default holds the worst case 256*31 = 7936 without overflow.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  run request; sampled only in IDLE or DONE.
- addr  out  ADDR_W  shared pixel/weight read address.
- pixel_in  in  1  pixel RAM read data; valid the cycle after its address.
- weight_in  in  SIZE  weight RAM read data; valid the cycle after its address.
- mul_multiplier  out  SIZE  to multiplier; combinational copy of weight_in.
- mul_multiplicand  out  1  to multiplier; combinational copy of pixel_in.
- mul_product  in  SIZE  multiplier result (combinational).
- acc_out  out  ACC_W  registered result of the last completed run.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse; acc_out is valid from this cycle onward.

## Operation
- States:
  - IDLE: start=1 clears the internal accumulator, sets addr=0 and goes to RUN.
  - RUN: addr increments every cycle. The product for the address issued in the previous cycle is added, except in the first RUN cycle, which has no data yet. After addr=N_INPUTS-1 is issued, go to DRAIN.
  - DRAIN: adds the last product and goes to DONE.
  - DONE: loads acc_out from the accumulator and pulses done. start=1 begins a new run (same actions as in IDLE); otherwise go to IDLE.
- A one-bit data-valid pipeline flag gates accumulation. No product is added outside RUN/DRAIN.
- Arithmetic:
  - Products are unsigned SIZE bits, zero-extended to ACC_W.
  - Default overflow behaviour is modulo 2^ACC_W (wrap).
- start is ignored while busy=1. A run cannot be aborted except by reset.
- addr holds its last value in IDLE/DONE. The RAMs ignore reads outside RUN.
- acc_out changes only in the DONE cycle and holds between runs.

## Timing
- Reset values: state=IDLE, addr=0, internal accumulator=0, acc_out=0, busy=0, done=0.
- Cycle numbering:
  - Cycle 0: start sampled high.
  - Cycles 1..N_INPUTS: RUN; addr equals cycle-1.
  - Cycle N_INPUTS+1: DRAIN.
  - Cycle N_INPUTS+2: DONE; done=1, acc_out is final. This is cycle 258 at defaults.
- busy is high for cycles 1..N_INPUTS+1, which is 257 cycles at defaults.
- A start in the DONE cycle makes the next cycle RUN with addr=0. The throughput is one result per N_INPUTS+2 cycles.
- Reset during RUN or DRAIN takes effect at the next edge: state=IDLE, accumulator and acc_out cleared, no done pulse.
- The multiplier path is combinational within one cycle: pixel_in/weight_in to mul_product to the accumulator adder.

## Configuration
- SATURATE_EN:
  - Defined: an accumulate that would exceed 2^ACC_W-1 clamps to 2^ACC_W-1 and stays there for the rest of the run.
  - Undefined: the accumulator wraps modulo 2^ACC_W.
  - Either way, the accumulator is cleared on start and on reset.

## Test plan
- All pixels 1, all weights 31, defaults -> done in cycle 258, acc_out=7936, busy high cycles 1..257.
- Only pixel 0 (weight 7) and pixel 255 (weight 9) set, other weights 31 -> acc_out=16. This checks both pipeline edges and the zero gating on multiplicand=0.
- start pulsed again at cycle 100 of a run (all ones/31) -> ignored; single done at cycle 258, acc_out=7936.
- Run 1 with all ones/31, with start held high in its DONE cycle; run 2 with all pixels 0 -> run 1 acc_out=7936; run 2 done 258 cycles after that start, acc_out=0 (accumulator cleared).
- rst_n low for one cycle at cycle 150 -> next cycle state IDLE, busy=0, acc_out=0, no done. A fresh run afterwards completes normally.
- ACC_W=8, all ones/31 -> with SATURATE_EN acc_out=255; without it acc_out=0 (7936 mod 256).
